midi_uart_rx: RTL and testbench

MIDI_UART_RX -- requirements
Module: midi_uart_rx

---
 rtl/midi_pkg.sv | 38 +++
 rtl/midi_bit_timer.sv | 55 +++++
 rtl/midi_uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_midi_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI receive path.
//   rx_state_e - receiver FSM states
//   MIDI_BAUD  - standard MIDI bit rate
//   status range constants and msg_len(), the number of data bytes that
//   complete a channel message for a given status byte.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned MIDI_BAUD = 31250;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] PROG_CH  = 8'hC0;
  localparam logic [7:0] CH_PRESS = 8'hD0;
  localparam logic [7:0] PITCH    = 8'hE0;
  localparam logic [7:0] SYS      = 8'hF0;
  localparam logic [7:0] RT       = 8'hF8;

  // Program change and channel pressure carry one data byte; the other
  // channel messages carry two. Non-channel statuses have no length.
  function automatic logic [7:0] msg_len(input logic [7:0] status);
    if (status >= PROG_CH && status < PITCH) begin
      // covers PROG_CH..CH_PRESS+0x0F
      msg_len = (status < CH_PRESS || status >= CH_PRESS) ? 8'd1 : 8'd0;
    end else if ((status >= NOTE_OFF && status < PROG_CH) ||
                 (status >= PITCH && status < SYS)) begin
      msg_len = 8'd2;
    end else begin
      msg_len = 8'd0;
    end
  endfunction

endpackage

// File: rtl/midi_bit_timer.sv
// midi_bit_timer: loadable down-counter for UART bit timing.
//   clk_i       - clock
//   rst_i       - synchronous active-high reset
//   load_half_i - start a HALF-clock interval
//   load_full_i - start a FULL-clock interval (wins over load_half_i)
//   expire_o    - one-cycle pulse when the loaded interval has elapsed
module midi_bit_timer #(
  parameter int unsigned FULL = 800,
  parameter int unsigned HALF = 400
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(FULL + 1);
  localparam logic [W-1:0] FULL_M1 = W'(FULL - 1);
  localparam logic [W-1:0] HALF_M1 = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  assign expire_o = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_full_i) begin
      cnt_d = FULL_M1;
      run_d = 1'b1;
    end else if (load_half_i) begin
      cnt_d = HALF_M1;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: MIDI serial receiver with running-status tracking.
//   CLOCK_25       - clock (CLK_HZ)
//   reset          - synchronous active-high reset
//   midi_rxd       - asynchronous serial input, idle high
//   byteready      - one-cycle pulse, midi_byte valid
//   midi_byte      - last byte received
//   cur_status     - current running-status byte
//   midibyte_nr    - data-byte index within the current message (0..2)
//   midi_data_byte - last data byte received for a channel message
//   msg_done       - one-cycle pulse with byteready when a message completes
//   frame_err      - one-cycle pulse on a bad stop bit
// Build option: MIDI_REALTIME_FILTER_EN drops real-time bytes 0xF8..0xFF
// completely; otherwise they are reported via byteready/midi_byte only.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25000000,
  parameter int unsigned BAUD   = MIDI_BAUD
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       midi_rxd,
  output logic       byteready,
  output logic [7:0] midi_byte,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_data_byte,
  output logic       msg_done,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  logic      sync1_q, sync2_q, prev_q;
  logic      fall;
  rx_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic      wait_high_q, wait_high_d;
  logic      load_half, load_full, expire;
  logic      byte_ok;

  logic       byteready_q, byteready_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] status_q, status_d;
  logic [7:0] nr_q, nr_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic [7:0] len;
  logic [7:0] nr_next;

  assign fall = prev_q && !sync2_q;

  midi_bit_timer #(
    .FULL(CLKS_PER_BIT),
    .HALF(CLKS_PER_BIT / 2)
  ) u_timer (
    .clk_i      (CLOCK_25),
    .rst_i      (reset),
    .load_half_i(load_half),
    .load_full_i(load_full),
    .expire_o   (expire)
  );

  // Frame FSM
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    load_half   = 1'b0;
    load_full   = 1'b0;
    byte_ok     = 1'b0;
    ferr_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wait_high_q) begin
          if (sync2_q) wait_high_d = 1'b0;
        end else if (fall) begin
          state_d   = ST_START;
          bitcnt_d  = '0;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (expire) begin
          if (!sync2_q) begin
            state_d   = ST_DATA;
            load_full = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          load_full = 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (expire) begin
          state_d = ST_IDLE;
          if (sync2_q) begin
            byte_ok = 1'b1;
          end else begin
            ferr_d      = 1'b1;
            wait_high_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Message decode: all outputs update together, one cycle after the stop sample
  always_comb begin
    byteready_d = 1'b0;
    done_d      = 1'b0;
    byte_d      = byte_q;
    status_d    = status_q;
    nr_d        = nr_q;
    data_d      = data_q;
    len         = msg_len(status_q);
    // Running status: a full message restarts the index at the first data byte
    nr_next     = (nr_q == len) ? 8'd1 : nr_q + 8'd1;
    if (byte_ok) begin
      if (shift_q >= RT) begin
`ifdef MIDI_REALTIME_FILTER_EN
        byteready_d = 1'b0;
`else
        byteready_d = 1'b1;
        byte_d      = shift_q;
`endif
      end else if (shift_q[7]) begin
        byteready_d = 1'b1;
        byte_d      = shift_q;
        status_d    = shift_q;
        nr_d        = '0;
      end else begin
        byteready_d = 1'b1;
        byte_d      = shift_q;
        if (status_q >= NOTE_OFF && status_q < SYS) begin
          nr_d   = nr_next;
          data_d = shift_q;
          done_d = (nr_next == len);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      byteready_q <= 1'b0;
      byte_q      <= '0;
      status_q    <= '0;
      nr_q        <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync1_q     <= midi_rxd;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      byteready_q <= byteready_d;
      byte_q      <= byte_d;
      status_q    <= status_d;
      nr_q        <= nr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
    end
  end

  assign byteready      = byteready_q;
  assign midi_byte      = byte_q;
  assign cur_status     = status_q;
  assign midibyte_nr    = nr_q;
  assign midi_data_byte = data_q;
  assign msg_done       = done_q;
  assign frame_err      = ferr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: directed bench for midi_uart_rx at 32 clocks per bit.
// Build option MIDI_REALTIME_FILTER_EN selects the real-time expectations.
module tb_midi_uart_rx;
  import midi_pkg::*;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 31250;
  localparam int unsigned CPB    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       byteready, msg_done, frame_err;
  logic [7:0] midi_byte, cur_status, midibyte_nr, midi_data_byte;

  int n_checks = 0;
  int n_errors = 0;

  int br_cnt = 0;
  int md_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] last_byte, last_status, last_nr, last_data;
  logic       last_done;

  always #5 clk = ~clk;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .CLOCK_25      (clk),
    .reset         (rst),
    .midi_rxd      (rxd),
    .byteready     (byteready),
    .midi_byte     (midi_byte),
    .cur_status    (cur_status),
    .midibyte_nr   (midibyte_nr),
    .midi_data_byte(midi_data_byte),
    .msg_done      (msg_done),
    .frame_err     (frame_err)
  );

  always @(negedge clk) begin
    if (byteready) begin
      br_cnt      <= br_cnt + 1;
      last_byte   <= midi_byte;
      last_status <= cur_status;
      last_nr     <= midibyte_nr;
      last_data   <= midi_data_byte;
      last_done   <= msg_done;
    end
    if (msg_done)  md_cnt <= md_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v = b;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(v[i]);
    bit_time(stop_bit);
    if (!stop_bit) bit_time(1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_br"},   {31'd0, byteready}, 32'd0);
    check({tag, "_byte"}, {24'd0, midi_byte}, 32'd0);
    check({tag, "_stat"}, {24'd0, cur_status}, 32'd0);
    check({tag, "_nr"},   {24'd0, midibyte_nr}, 32'd0);
    check({tag, "_data"}, {24'd0, midi_data_byte}, 32'd0);
    check({tag, "_flags"}, {30'd0, msg_done, frame_err}, 32'd0);
  endtask

  int br0, md0, fe0;
  logic [7:0] rbyte;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Note-on with two data bytes
    send(8'h90);
    check("s90_br", br_cnt, 1);
    check("s90_stat", last_status, 8'h90);
    check("s90_nr", last_nr, 0);
    send(8'h3C);
    check("d3C_nr", last_nr, 1);
    check("d3C_data", last_data, 8'h3C);
    check("d3C_md", md_cnt, 0);
    send(8'h64);
    check("d64_br", br_cnt, 3);
    check("d64_nr", last_nr, 2);
    check("d64_data", last_data, 8'h64);
    check("d64_done", {31'd0, last_done}, 1);
    check("d64_md", md_cnt, 1);

    // Running status
    send(8'h40);
    check("rs40_nr", last_nr, 1);
    check("rs40_md", md_cnt, 1);
    send(8'h00);
    check("rs00_nr", last_nr, 2);
    check("rs00_md", md_cnt, 2);
    check("rs00_stat", last_status, 8'h90);

    // Program change, one data byte
    send(8'hC5);
    check("sC5_stat", last_status, 8'hC5);
    check("sC5_nr", last_nr, 0);
    send(8'h07);
    check("d07_nr", last_nr, 1);
    check("d07_md", md_cnt, 3);
    send(8'h09);
    check("d09_nr", last_nr, 1);
    check("d09_md", md_cnt, 4);
    check("d09_data", last_data, 8'h09);

    // Short glitch and bad stop bit
    br0 = br_cnt;
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_br", br_cnt, br0);
    check("glitch_fe", fe_cnt, fe0);
    send_frame(8'hAA, 1'b0);
    check("ferr_fe", fe_cnt, fe0 + 1);
    check("ferr_br", br_cnt, br0);
    send(8'h55);
    check("after_ferr_br", br_cnt, br0 + 1);
    check("after_ferr_byte", last_byte, 8'h55);

    // Real-time byte inside a message
    send(8'h90);
    send(8'h3C);
    br0 = br_cnt;
    md0 = md_cnt;
    send(8'hF8);
`ifdef MIDI_REALTIME_FILTER_EN
    check("rt_br", br_cnt, br0);
    check("rt_byte", midi_byte, 8'h3C);
`else
    check("rt_br", br_cnt, br0 + 1);
    check("rt_byte", last_byte, 8'hF8);
    check("rt_nr", last_nr, 1);
`endif
    check("rt_stat", cur_status, 8'h90);
    send(8'h64);
    check("rt64_nr", last_nr, 2);
    check("rt64_data", last_data, 8'h64);
    check("rt64_md", md_cnt, md0 + 1);
`ifdef MIDI_REALTIME_FILTER_EN
    check("rt64_br", br_cnt, br0 + 1);
`else
    check("rt64_br", br_cnt, br0 + 2);
`endif

    // Reset in the middle of data bit 4 of 0xF0 (no falling edge after it)
    br0 = br_cnt;
    md0 = md_cnt;
    fe0 = fe_cnt;
    rbyte = 8'hF0;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(rbyte[i]);
    rxd = rbyte[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) bit_time(rbyte[i]);
    bit_time(1'b1);
    repeat (CPB) @(negedge clk);
    check("midrst_br", br_cnt, br0);
    check("midrst_md", md_cnt, md0);
    check("midrst_fe", fe_cnt, fe0);
    send(8'hB0);
    check("postrst_br", br_cnt, br0 + 1);
    check("postrst_stat", cur_status, 8'hB0);
    check("postrst_nr", midibyte_nr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
